// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issues the lowest-index ready ALU station entry, executes it in one cycle
// and holds the result on the CDB until the arbiter grants it.
module alu_issue_unit #(
  parameter int num_rs = 4,
  parameter int data_width = 16,
  parameter int tag_width = 3
) (
  input  logic                           clk,
  input  logic                           flush,
  input  logic [num_rs-1:0]              rs_busy,
  input  logic [num_rs-1:0]              rs_Vj_valid,
  input  logic [num_rs-1:0]              rs_Vk_valid,
  input  logic [num_rs*data_width-1:0]   rs_Vj,
  input  logic [num_rs*data_width-1:0]   rs_Vk,
  input  logic [num_rs*4-1:0]            rs_op,
  input  logic [num_rs*tag_width-1:0]    rs_dest,
  output logic [num_rs-1:0]              issue_clr,
  output logic                           cdb_req,
  input  logic                           cdb_grant,
  output logic [tag_width-1:0]           cdb_tag,
  output logic [data_width-1:0]          cdb_value,
  output logic                           unit_busy
);
  typedef enum logic [1:0] {IDLE, EXEC, BCAST} state_t;
  state_t state;
  logic [3:0] ex_op, sel_op;
  logic [data_width-1:0] ex_vj, ex_vk, sel_vj, sel_vk, result;
  logic [tag_width-1:0] ex_dest, sel_dest;
  logic [num_rs-1:0] ready, first;
  logic issue;
  assign ready = rs_busy & rs_Vj_valid & rs_Vk_valid;
  // two's-complement trick isolates the lowest set bit as a one-hot select
  assign first = ready & (~ready + num_rs'(1));
  assign issue = !flush && |ready && (state == IDLE || (state == BCAST && cdb_grant));
  assign issue_clr = issue ? first : '0;
  assign unit_busy = state != IDLE;
  assign result = ex_op == 4'b0001 ? ex_vj + ex_vk :
                  ex_op == 4'b0101 ? ex_vj & ex_vk :
                  ex_op == 4'b1001 ? ~ex_vj : ex_vk;
  always_comb begin
    sel_vj = '0;
    sel_vk = '0;
    sel_op = '0;
    sel_dest = '0;
    for (int i = 0; i < num_rs; i++) begin
      sel_vj = sel_vj | ({data_width{first[i]}} & rs_Vj[i*data_width +: data_width]);
      sel_vk = sel_vk | ({data_width{first[i]}} & rs_Vk[i*data_width +: data_width]);
      sel_op = sel_op | ({4{first[i]}} & rs_op[i*4 +: 4]);
      sel_dest = sel_dest | ({tag_width{first[i]}} & rs_dest[i*tag_width +: tag_width]);
    end
  end
  always_ff @(posedge clk) begin
    if (flush) begin
      state <= IDLE;
      ex_op <= '0;
      ex_vj <= '0;
      ex_vk <= '0;
      ex_dest <= '0;
      cdb_req <= 1'b0;
      cdb_tag <= '0;
      cdb_value <= '0;
    end else if (issue) begin
      ex_op <= sel_op;
      ex_vj <= sel_vj;
      ex_vk <= sel_vk;
      ex_dest <= sel_dest;
      cdb_req <= 1'b0;
      state <= EXEC;
    end else if (state == EXEC) begin
      cdb_value <= result;
      cdb_tag <= ex_dest;
      cdb_req <= 1'b1;
      state <= BCAST;
    end else if (state == BCAST && cdb_grant) begin
      cdb_req <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: table vectors, directed corner sequences and a randomized run
// checked against a transaction-level model of the issue unit.
module tb_alu_issue_unit;
  localparam int N = 4;
  logic clk = 0, flush = 1, cdb_grant = 0;
  logic [N-1:0] bsy = '0, vjv = '0, vkv = '0, issue_clr;
  logic [15:0] vj [N], vk [N];
  logic [3:0] op [N];
  logic [2:0] dst [N];
  logic [N*16-1:0] rs_Vj, rs_Vk;
  logic [N*4-1:0] rs_op;
  logic [N*3-1:0] rs_dest;
  logic cdb_req, unit_busy;
  logic [2:0] cdb_tag;
  logic [15:0] cdb_value;
  int total = 0, passed = 0, cyc = 0, icyc = 0;
  bit inflight = 0;
  logic [2:0] m_tag;
  logic [15:0] m_val;
  logic [N-1:0] e_clr, s_clr;
  logic s_req, s_busy;
  logic [2:0] s_tag;
  logic [15:0] s_val;

  typedef struct {int e; logic [3:0] op; logic [15:0] vj, vk; logic [2:0] dest; logic [15:0] exp;} vec_t;
  vec_t vt [5];

  always #5 clk = ~clk;

  always_comb begin
    rs_Vj = '0;
    rs_Vk = '0;
    rs_op = '0;
    rs_dest = '0;
    for (int i = 0; i < N; i++) begin
      rs_Vj[i*16 +: 16] = vj[i];
      rs_Vk[i*16 +: 16] = vk[i];
      rs_op[i*4 +: 4] = op[i];
      rs_dest[i*3 +: 3] = dst[i];
    end
  end

  alu_issue_unit #(.num_rs(N), .data_width(16), .tag_width(3)) dut (
    .clk(clk), .flush(flush), .rs_busy(bsy), .rs_Vj_valid(vjv), .rs_Vk_valid(vkv),
    .rs_Vj(rs_Vj), .rs_Vk(rs_Vk), .rs_op(rs_op), .rs_dest(rs_dest), .issue_clr(issue_clr),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .unit_busy(unit_busy));

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    total++;
    if (a === x) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, x, cyc);
  endtask

  function automatic logic [15:0] alu(logic [3:0] o, logic [15:0] a, logic [15:0] b);
    case (o)
      4'b0001: return 16'((32'(a) + 32'(b)) % 65536);
      4'b0101: return a & b;
      4'b1001: return 16'hFFFF - a;
      default: return b;
    endcase
  endfunction

  // one clock: sample and check at negedge, advance model, then retire the issued entry
  task automatic step();
    bit bc;
    int sel;
    logic [N-1:0] rdy;
    @(negedge clk);
    s_clr = issue_clr; s_req = cdb_req; s_tag = cdb_tag; s_val = cdb_value; s_busy = unit_busy;
    bc = inflight && cyc >= icyc + 2;
    rdy = bsy & vjv & vkv;
    sel = -1;
    for (int i = N - 1; i >= 0; i--) if (rdy[i]) sel = i;
    e_clr = '0;
    if ((!inflight || (bc && cdb_grant)) && !flush && sel >= 0) e_clr[sel] = 1'b1;
    chk("issue_clr", 32'(s_clr), 32'(e_clr));
    chk("cdb_req", 32'(s_req), 32'(bc));
    chk("unit_busy", 32'(s_busy), 32'(inflight));
    if (bc) begin
      chk("cdb_tag", 32'(s_tag), 32'(m_tag));
      chk("cdb_value", 32'(s_val), 32'(m_val));
    end
    if (flush) inflight = 0;
    else begin
      if (bc && cdb_grant) inflight = 0;
      if (e_clr != 0) begin
        inflight = 1; icyc = cyc; m_tag = dst[sel]; m_val = alu(op[sel], vj[sel], vk[sel]);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    bsy = bsy & ~e_clr;
  endtask

  task automatic load(int e, logic [3:0] o, logic [15:0] a, logic [15:0] b, logic [2:0] d);
    bsy[e] = 1; vjv[e] = 1; vkv[e] = 1; op[e] = o; vj[e] = a; vk[e] = b; dst[e] = d;
  endtask

  task automatic drain();
    bsy = '0; cdb_grant = 1;
    repeat (4) step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin vj[i] = 0; vk[i] = 0; op[i] = 0; dst[i] = 0; end
    vt[0] = '{2, 4'b0001, 16'h7FFF, 16'h0001, 3'd5, 16'h8000};
    vt[1] = '{0, 4'b0001, 16'hFFFF, 16'h0002, 3'd1, 16'h0001};
    vt[2] = '{1, 4'b0101, 16'hF0F0, 16'h3C3C, 3'd2, 16'h3030};
    vt[3] = '{3, 4'b1001, 16'h00F0, 16'h1111, 3'd3, 16'hFF0F};
    vt[4] = '{0, 4'b1110, 16'hAAAA, 16'h1234, 3'd6, 16'h1234};
    step(); step();
    chk("rst_req", 32'(cdb_req), 0);
    chk("rst_tag", 32'(cdb_tag), 0);
    chk("rst_value", 32'(cdb_value), 0);
    chk("rst_busy", 32'(unit_busy), 0);
    flush = 0;
    // table vectors: single issue with grant held
    foreach (vt[k]) begin
      bsy = '0; cdb_grant = 1;
      load(vt[k].e, vt[k].op, vt[k].vj, vt[k].vk, vt[k].dest);
      step();
      chk("vec_clr", 32'(s_clr), 32'(1 << vt[k].e));
      step();
      step();
      chk("vec_req", 32'(s_req), 1);
      chk("vec_value", 32'(s_val), 32'(vt[k].exp));
      chk("vec_tag", 32'(s_tag), 32'(vt[k].dest));
      step();
      chk("vec_idle", 32'(s_busy), 0);
    end
    // priority: entries 1 and 3 ready together
    drain();
    load(1, 4'b0001, 16'd10, 16'd20, 3'd1);
    load(3, 4'b0101, 16'hFF00, 16'h0FF0, 3'd7);
    step();
    chk("prio_first", 32'(s_clr), 32'b0010);
    step();
    step();
    chk("prio_second", 32'(s_clr), 32'b1000);
    chk("prio_tag1", 32'(s_tag), 1);
    step();
    step();
    chk("prio_tag3", 32'(s_tag), 7);
    chk("prio_val3", 32'(s_val), 32'h0F00);
    // stall: result held while grant is low
    drain();
    cdb_grant = 0;
    load(0, 4'b1001, 16'h00F0, 16'h0000, 3'd3);
    step();
    step();
    load(1, 4'b0001, 16'd1, 16'd2, 3'd4);
    repeat (4) begin
      step();
      chk("stall_req", 32'(s_req), 1);
      chk("stall_val", 32'(s_val), 32'hFF0F);
      chk("stall_tag", 32'(s_tag), 3);
      chk("stall_clr", 32'(s_clr), 0);
    end
    cdb_grant = 1;
    step();
    chk("stall_issue", 32'(s_clr), 32'b0010);
    // flush in BCAST before grant
    drain();
    cdb_grant = 0;
    load(0, 4'b0001, 16'd1, 16'd1, 3'd4);
    step(); step(); step();
    chk("fl_req_pre", 32'(s_req), 1);
    load(2, 4'b0101, 16'hFFFF, 16'h00FF, 3'd2);
    flush = 1;
    step();
    chk("fl_clr", 32'(s_clr), 0);
    chk("fl_req", 32'(cdb_req), 0);
    chk("fl_value", 32'(cdb_value), 0);
    chk("fl_tag", 32'(cdb_tag), 0);
    chk("fl_busy", 32'(unit_busy), 0);
    flush = 0;
    step();
    chk("fl_after_clr", 32'(s_clr), 32'b0100);
    // not ready: every busy entry lacks an operand
    drain();
    bsy = 4'b1111; vjv = 4'b0101; vkv = 4'b1010;
    repeat (3) begin
      step();
      chk("nr_clr", 32'(s_clr), 0);
      chk("nr_busy", 32'(s_busy), 0);
    end
    // randomized run against the model
    bsy = '0;
    repeat (600) begin
      cdb_grant = ($urandom % 4) != 0;
      flush = ($urandom % 60) == 0;
      for (int i = 0; i < N; i++) begin
        if (!bsy[i]) begin
          if ($urandom % 3 == 0) begin
            bsy[i] = 1; vjv[i] = 1'($urandom); vkv[i] = 1'($urandom);
            vj[i] = 16'($urandom); vk[i] = 16'($urandom); dst[i] = 3'($urandom);
            case ($urandom % 4)
              0: op[i] = 4'b0001;
              1: op[i] = 4'b0101;
              2: op[i] = 4'b1001;
              default: op[i] = 4'($urandom);
            endcase
          end
        end else begin
          if ($urandom % 3 == 0) vjv[i] = 1;
          if ($urandom % 3 == 0) vkv[i] = 1;
        end
      end
      step();
    end
    flush = 0;
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Consumer side of the ALU reservation-station entries. Each cycle it scans the station array for the lowest-index entry that is busy with both operands valid. It issues that entry, pulsing the entry's busy-clear, and executes the operation. It then broadcasts the result and destination tag on the common data bus (CDB) through a request/grant handshake with the CDB arbiter.

## Interface
Parameters:
- num_rs, 4, number of reservation-station entries scanned (1..8)
- data_width, 16, operand/result width
- tag_width, 3, ROB tag width

Ports:
- clk  in  1  clock, all state on rising edge
- flush  in  1  synchronous active-high reset; also used as pipeline flush
- rs_busy  in  num_rs  per-entry busy bit (bit i = entry i)
- rs_Vj_valid  in  num_rs  per-entry Vj operand valid
- rs_Vk_valid  in  num_rs  per-entry Vk operand valid
- rs_Vj  in  num_rs*data_width  entry i Vj at bits [i*data_width +: data_width]
- rs_Vk  in  num_rs*data_width  entry i Vk, same packing
- rs_op  in  num_rs*4  entry i lc3b_opcode at [i*4 +: 4]
- rs_dest  in  num_rs*tag_width  entry i destination tag
- issue_clr  out  num_rs  one-hot; bit i high drives entry i ld_busy with busy_in=0
- cdb_req  out  1  result valid, requesting CDB
- cdb_grant  in  1  arbiter accepts result this cycle
- cdb_tag  out  tag_width  destination tag of broadcast result
- cdb_value  out  data_width  broadcast result
- unit_busy  out  1  high when state is not IDLE

## Operation
- ready[i] = rs_busy[i] & rs_Vj_valid[i] & rs_Vk_valid[i]. The selected entry sel is the lowest i with ready[i].
- Issue condition: the issue opportunity exists (state IDLE, or state BCAST with cdb_grant) and any ready[i] is high, and flush is low.
- issue_clr is combinational and one-hot at sel only under the issue condition; otherwise it is 0.
- On issue, latch op, Vj, Vk and dest of sel into execute registers, then go to EXEC.
- EXEC lasts one cycle. It computes the result into the result register:
  - op_add (4'b0001): Vj+Vk, modulo 2^data_width, carry dropped
  - op_and (4'b0101): Vj&Vk
  - op_not (4'b1001): ~Vj
  - any other opcode: Vk passed through
- On leaving EXEC, cdb_tag is loaded with the latched dest, and the state goes to BCAST.
- BCAST: cdb_req=1. cdb_value and cdb_tag are held stable until cdb_grant.
  - grant with an issue condition: the next state is EXEC (back-to-back).
  - grant without one: the next state is IDLE.
  - no grant: stay in BCAST; no new issue.
- States and transitions:
  - IDLE: goes to EXEC on issue, otherwise stays.
  - EXEC: always goes to BCAST.
  - BCAST: stays while !cdb_grant; on grant goes to EXEC if issuing, else IDLE.
- Reading only registered station outputs is safe. An entry is cleared at the same edge it is issued, and the next issue is at least two cycles later, so no entry is selected twice.
- Flush overrides everything at the edge:
  - state goes to IDLE; cdb_req, cdb_tag, cdb_value and the execute registers go to 0
  - issue_clr is forced 0 in the flush cycle
  - a pending un-granted result is discarded
- cdb_grant while cdb_req=0 is ignored.

## Timing
- Reset values: state IDLE, cdb_req 0, cdb_tag 0, cdb_value 0, issue_clr 0, unit_busy 0.
- Entry ready in cycle t with the unit IDLE:
  - issue_clr pulses in cycle t
  - EXEC in t+1
  - cdb_req high from t+2
- Minimum issue-to-broadcast latency is 2 cycles.
- With cdb_grant held high, peak throughput is one result per 2 cycles. The grant cycle of result n is the issue cycle of result n+1.
- Simultaneous ready entries: only the lowest index issues. Higher entries wait for the next issue opportunity.
- Operands are sampled only in the issue cycle. Later station changes do not affect an in-flight result.

## Test plan
- Single ADD: entry 2 busy, Vj=0x7FFF, Vk=0x0001, op 0001, dest 5; grant held 1.
  - Expected: issue_clr=0100 in cycle t; cdb_req at t+2 with value 0x8000, tag 5; IDLE at t+3.
- Priority: entries 1 and 3 ready at the same time.
  - Expected: entry 1 issues first.
  - Entry 3 issues in the grant cycle of entry 1's result; results appear in the order 1, 3.
- Stall: NOT Vj=0x00F0, dest 3; hold cdb_grant=0 for 4 cycles, ready entries present.
  - Expected: cdb_req stays 1 with value 0xFF0F, tag 3, stable; issue_clr stays 0; issue on the grant cycle.
- Wrap/AND/default ops:
  - ADD 0xFFFF+0x0002: expect 0x0001.
  - AND 0xF0F0&0x3C3C: expect 0x3030.
  - opcode 1110 with Vk=0x1234: expect 0x1234.
- Flush in BCAST before grant: cdb_req 0 next cycle, state IDLE, result never granted.
  - Ready entry during the flush cycle: expect issue_clr=0.
- Not ready: rs_busy=1111 but each entry is missing Vj_valid or Vk_valid.
  - Expected: issue_clr stays 0, unit stays IDLE.
